// File: rtl/serial_regfile_ctrl_if.sv
// serial_regfile_ctrl_if: command/data port of the byte-serial register file front end.
interface serial_regfile_ctrl_if #(parameter int IN_W = 8);
  logic [1:0]      cmd;
  logic [IN_W-1:0] din;
  logic [IN_W-1:0] dout;
  logic            busy;
  logic            loaded;
  logic            err;
  modport master (output cmd, din, input dout, busy, loaded, err);
  modport slave  (input cmd, din, output dout, busy, loaded, err);
endinterface

// File: rtl/serial_regfile_ctrl.sv
// serial_regfile_ctrl: shift in a {data, addr} frame, read/write a register file, stream data back out.
// Define ADDR_AUTOINC_EN to step the address field after every in-range read or write.
module serial_regfile_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int IN_W   = 8
) (
  input logic clk,
  input logic rst_n,
  serial_regfile_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int AFLD_W = (ADDR_W + IN_W - 1) / IN_W * IN_W;
  localparam int SR_W   = DATA_W + AFLD_W;
  localparam int NSHIFT = SR_W / IN_W;
  localparam int CNT_W  = $clog2(NSHIFT + 1);
  typedef enum logic {IDLE, RD} state_t;
  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [AFLD_W-1:0] addr, addr_nx;
  logic [ADDR_W-1:0] idx;
  logic              in_rng, full, we;
  assign addr   = sr_q[AFLD_W-1:0];
  assign idx    = addr[ADDR_W-1:0];
  // One extra bit so DEPTH=256 with an 8-bit field still compares correctly.
  assign in_rng = {1'b0, addr} < (AFLD_W+1)'(DEPTH);
  assign full   = cnt_q == CNT_W'(NSHIFT);
`ifdef ADDR_AUTOINC_EN
  assign addr_nx = !in_rng ? addr : addr == AFLD_W'(DEPTH - 1) ? '0 : addr + AFLD_W'(1);
`else
  assign addr_nx = addr;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && we) rf[idx] <= sr_q[SR_W-1:AFLD_W];
  // Commands are only decoded in IDLE, so the address field is stable through RD.
  always_comb begin
    state_d = IDLE;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
    if (state_q == RD) begin
      sr_d  = {in_rng ? rf[idx] : DATA_W'(0), addr_nx};
      err_d = !in_rng;
      cnt_d = '0;
    end else begin
      case (bus.cmd)
        2'b01: begin
          sr_d  = {sr_q[SR_W-IN_W-1:0], bus.din};
          cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
        end
        2'b10: state_d = RD;
        2'b11: begin
          we    = in_rng;
          err_d = !in_rng;
          cnt_d = '0;
          sr_d[AFLD_W-1:0] = addr_nx;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    bus.busy   = state_q == RD;
    bus.loaded = full;
    bus.err    = err_q;
    bus.dout   = sr_q[SR_W-1 -: IN_W];
  end
endmodule
